// File: rtl/avalon_gpio_in_slave_pkg.sv
//============================================================================
// Package  : gpio_in_pkg
// Brief    : Register offsets and default tick divider for the GPIO input slave
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package gpio_in_pkg;
    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd2;
    localparam logic [1:0] ADDR_EDGE_SEL = 2'd3;

    // 1 ms sample period at a 25 MHz system clock
    localparam int c_tick_div_default = 25000;
endpackage

`default_nettype wire

// File: rtl/avalon_gpio_in_slave_if.sv
//============================================================================
// Interface : avalon_gpio_in_slave_if
// Brief     : Avalon-MM word-addressed bus, fixed read latency 1, no waitrequest
// Revision  : 1.0 - initial release
//============================================================================
`default_nettype none

interface avalon_gpio_in_slave_if;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );
endinterface

`default_nettype wire

// File: rtl/avalon_gpio_in_slave_debounce.sv
//============================================================================
// Module   : gpio_debounce
// Brief    : 2-FF synchroniser plus 3-sample tick debouncer, one lane per bit
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module gpio_debounce #(
    parameter int               WIDTH    = 14,
    parameter logic [WIDTH-1:0] INIT_VAL = 14'h000F
) (
    input  wire              clk,
    input  wire              reset_n,
    input  wire              tick,
    input  wire  [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] debounced
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_hist0;
    logic [WIDTH-1:0] r_hist1;
    logic [WIDTH-1:0] r_deb;
    logic [WIDTH-1:0] w_stable;

    // A lane only moves when the current sample agrees with the two before it
    assign w_stable  = ~(r_sync2 ^ r_hist0) & ~(r_sync2 ^ r_hist1);
    assign debounced = r_deb;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= INIT_VAL;
            r_sync2 <= INIT_VAL;
            r_hist0 <= INIT_VAL;
            r_hist1 <= INIT_VAL;
            r_deb   <= INIT_VAL;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (tick) begin
                r_hist0 <= r_sync2;
                r_hist1 <= r_hist0;
                r_deb   <= (r_deb & ~w_stable) | (r_sync2 & w_stable);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/avalon_gpio_in_slave.sv
//============================================================================
// Module   : avalon_gpio_in_slave
// Brief    : Debounced KEY/SW input bank with sticky edge capture and masked IRQ
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module avalon_gpio_in_slave
    import gpio_in_pkg::*;
#(
    parameter int               WIDTH    = 14,
    parameter int               TICK_DIV = c_tick_div_default,
    parameter logic [WIDTH-1:0] INIT_VAL = 14'h000F
) (
    input  wire                          clk,
    input  wire                          reset_n,
    input  wire  [WIDTH-1:0]             gpio_in,
    avalon_gpio_in_slave_if.slave        avs,
    output logic                         irq
);

    localparam int                 c_cnt_w     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_tick_last = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_tick_cnt;
    logic [WIDTH-1:0]   r_deb_prev;
    logic [WIDTH-1:0]   r_irq_mask;
    logic [WIDTH-1:0]   r_edge_cap;
    logic [WIDTH-1:0]   r_edge_sel;
    logic [31:0]        r_readdata;
    logic               r_irq;

    logic               w_tick;
    logic [WIDTH-1:0]   w_debounced;
    logic [WIDTH-1:0]   w_rise;
    logic [WIDTH-1:0]   w_fall;
    logic [WIDTH-1:0]   w_sel_edge;
    logic [WIDTH-1:0]   w_clr;
    logic [31:0]        w_rd_mux;
    logic               w_unused_wdata;

    assign w_tick = (r_tick_cnt == c_tick_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    gpio_debounce #(
        .WIDTH    (WIDTH),
        .INIT_VAL (INIT_VAL)
    ) u_debounce (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (w_tick),
        .raw       (gpio_in),
        .debounced (w_debounced)
    );

    assign w_rise     = w_debounced & ~r_deb_prev;
    assign w_fall     = ~w_debounced & r_deb_prev;
    assign w_sel_edge = (r_edge_sel & w_rise) | (~r_edge_sel & w_fall);
    assign w_clr      = (avs.avs_write && (avs.avs_address == ADDR_EDGE_CAP))
                        ? avs.avs_writedata[WIDTH-1:0] : '0;

    // Bits above WIDTH carry no state
    assign w_unused_wdata = &{1'b0, avs.avs_writedata[31:WIDTH]};

    always_comb begin
        w_rd_mux = '0;
        case (avs.avs_address)
            ADDR_DATA:     w_rd_mux[WIDTH-1:0] = w_debounced;
            ADDR_IRQ_MASK: w_rd_mux[WIDTH-1:0] = r_irq_mask;
            ADDR_EDGE_CAP: w_rd_mux[WIDTH-1:0] = r_edge_cap;
            ADDR_EDGE_SEL: w_rd_mux[WIDTH-1:0] = r_edge_sel;
            default:       w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb_prev <= INIT_VAL;
            r_irq_mask <= '0;
            r_edge_cap <= '0;
            r_edge_sel <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_deb_prev <= w_debounced;
            // A fresh edge outranks a simultaneous W1C on the same bit
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_sel_edge;
            r_irq      <= |(r_edge_cap & r_irq_mask);
            if (avs.avs_write && (avs.avs_address == ADDR_IRQ_MASK)) begin
                r_irq_mask <= avs.avs_writedata[WIDTH-1:0];
            end
            if (avs.avs_write && (avs.avs_address == ADDR_EDGE_SEL)) begin
                r_edge_sel <= avs.avs_writedata[WIDTH-1:0];
            end
            if (avs.avs_read) begin
                r_readdata <= w_rd_mux;
            end
        end
    end

    assign avs.avs_readdata = r_readdata;
    assign irq              = r_irq;

endmodule

`default_nettype wire
